// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit end of the tty byte stream. Bytes from the flow port are queued in a
// small circular FIFO and shifted out as 8N1 asynchronous frames on `tx`.
// Each serial bit lasts CLK_DIV clock cycles.
// `state_dbg` exposes the frame FSM state for observation; its encoding is the
// state_t enum below.
//
// Handshake (in_valid/in_ready): a byte moves into the FIFO on a rising edge
// where in_valid and in_ready are both high. While in_ready is low, in_data and
// in_valid are ignored, and the source keeps presenting its pending byte.
// in_ready is low while the FIFO is full or while rst is asserted. A full FIFO
// refuses a byte even if the FSM pops in the same cycle, so there is no bypass
// path.

module uart_tx_serializer #(
    parameter int CLK_DIV = 417,  // clock cycles per serial bit, >= 2
    parameter int FIFO_AW = 4     // FIFO address width, depth = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic [1:0]         state_dbg
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // The pointers carry one extra wrap bit, so full and empty can be
    // told apart when the address bits are equal.
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wptr;
    logic [FIFO_AW:0]   rptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign empty = (wptr == rptr);
    assign head  = mem[rptr[FIFO_AW-1:0]];

    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;
    assign level    = wptr - rptr;

    // Write the incoming byte into the slot addressed by the write pointer.
    // The storage is not reset; the pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= in_data;
        end
    end

    // Advance the pointers on push/pop. Reset flushes the FIFO by equalising them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: shifter, bit counter, baud counter, line register
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [BAUD_W-1:0]   baud_q;
    logic [BAUD_W-1:0]   baud_d;
    logic [2:0]          bit_q;
    logic [2:0]          bit_d;
    logic [7:0]          shift_q;
    logic [7:0]          shift_d;
    logic                tx_q;
    logic                tx_d;
    logic                baud_zero;

    assign baud_zero = (baud_q == '0);

    // Register the FSM state, the counters, the shifter and the serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic. The baud counter runs CLK_DIV-1 down to 0, and each
    // bit period ends on the zero cycle. The line value is derived from the
    // state being entered, so `tx` changes on the same edge as the state and
    // needs no extra cycle of delay.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (baud_zero) begin
                    baud_d  = BAUD_LOAD;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (baud_zero) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end

            ST_STOP: begin
                if (baud_zero) begin
                    if (!empty) begin
                        // Chain straight into the next start bit, with no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = 3'd0;
                        baud_d  = BAUD_LOAD;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) | ~empty;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer.
// Three instances are used: CLK_DIV=4 for bit-exact frame patterns and reset
// mid-frame, CLK_DIV=8 for FIFO fill/stall/ordering, and the default 417 for
// the long low period. Outputs are sampled 1 time unit after the rising edge.

module tb_uart_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV = 4
    logic       rst_a, in_valid_a, in_ready_a, tx_a, busy_a;
    logic [7:0] in_data_a;
    logic [4:0] level_a;
    logic [1:0] state_a;

    // Instance B: CLK_DIV = 8
    logic       rst_b, in_valid_b, in_ready_b, tx_b, busy_b;
    logic [7:0] in_data_b;
    logic [4:0] level_b;
    logic [1:0] state_b;

    // Instance C: default CLK_DIV = 417
    logic       rst_c, in_valid_c, in_ready_c, tx_c, busy_c;
    logic [7:0] in_data_c;
    logic [4:0] level_c;
    logic [1:0] state_c;

    uart_tx_serializer #(.CLK_DIV(4), .FIFO_AW(4)) u_div4 (
        .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .level(level_a),
        .state_dbg(state_a)
    );

    uart_tx_serializer #(.CLK_DIV(8), .FIFO_AW(4)) u_div8 (
        .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .level(level_b),
        .state_dbg(state_b)
    );

    uart_tx_serializer u_div417 (
        .clk(clk), .rst(rst_c), .in_data(in_data_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .tx(tx_c), .busy(busy_c), .level(level_c),
        .state_dbg(state_c)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard for instance B: bytes accepted, and bytes decoded from tx.
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         frame_err_b = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record n consecutive tx_a samples (LSB = first cycle), one per clock.
    task automatic capture_a(input int n, output logic [79:0] v, output logic last_busy);
        v = '0;
        last_busy = 1'b0;
        for (int j = 0; j < n; j++) begin
            v[j] = tx_a;
            last_busy = busy_a;
            step();
        end
    endtask

    // Frame decoder for instance B: detect the first low cycle and sample
    // every bit mid-period (bit period 8, so the mid offset is 4).
    initial begin : mon_b
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (rst_b === 1'b0 && tx_b === 1'b0) begin
                repeat (12) @(posedge clk);
                #1;
                b[0] = tx_b;
                for (int i = 1; i < 8; i++) begin
                    repeat (8) @(posedge clk);
                    #1;
                    b[i] = tx_b;
                end
                repeat (8) @(posedge clk);
                #1;
                if (tx_b !== 1'b1) frame_err_b++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : stim
        logic [79:0] v;
        logic        lb;
        int          hs;
        int          guard;
        int          stall;
        int          low;
        logic [7:0]  nb;
        logic [7:0]  got;
        logic [7:0]  want;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        in_data_a = 8'h00; in_data_b = 8'h00; in_data_c = 8'h00;

        // ---------------- reset values ----------------
        repeat (3) step();
        check("rst_tx",       80'(tx_a),       80'd1);
        check("rst_busy",     80'(busy_a),     80'd0);
        check("rst_level",    80'(level_a),    80'd0);
        check("rst_in_ready", 80'(in_ready_a), 80'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        check("rst_release_in_ready", 80'(in_ready_a), 80'd1);
        step();

        // ---------------- single byte 0x55, CLK_DIV=4 ----------------
        in_data_a = 8'h55; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        check("single_level_after_push", 80'(level_a), 80'd1);
        check("single_tx_before_pop",    80'(tx_a),    80'd1);
        step();
        check("single_level_after_pop",  80'(level_a), 80'd0);
        capture_a(40, v, lb);
        check("single_frame_55",     v,            80'hF0F0F0F0F0);
        check("single_busy_in_stop", 80'(lb),      80'd1);
        check("single_busy_idle",    80'(busy_a),  80'd0);
        check("single_tx_idle",      80'(tx_a),    80'd1);

        // ---------------- back-to-back 0xA3, 0x0F ----------------
        step();
        in_data_a = 8'hA3; in_valid_a = 1'b1;
        step();
        check("b2b_level_first", 80'(level_a), 80'd1);
        in_data_a = 8'h0F;
        step();
        in_valid_a = 1'b0;
        check("b2b_level_overlap", 80'(level_a), 80'd1);
        capture_a(80, v, lb);
        check("b2b_frames_a3_0f", v,           80'hF0000FFFF0_FF0F000FF0);
        check("b2b_busy_in_stop", 80'(lb),     80'd1);
        check("b2b_busy_idle",    80'(busy_a), 80'd0);

        // ---------------- reset mid-frame ----------------
        step();
        for (int k = 0; k < 6; k++) begin
            in_data_a = 8'h10 + 8'(k);
            in_valid_a = 1'b1;
            step();
        end
        in_valid_a = 1'b0;
        repeat (12) step();
        check("midrst_level_before", 80'(level_a), 80'd5);
        check("midrst_tx_bit3",      80'(tx_a),    80'd0);
        rst_a = 1'b1;
        step();
        check("midrst_tx",       80'(tx_a),       80'd1);
        check("midrst_level",    80'(level_a),    80'd0);
        check("midrst_busy",     80'(busy_a),     80'd0);
        check("midrst_in_ready", 80'(in_ready_a), 80'd0);
        rst_a = 1'b0;
        #1;
        check("midrst_release_ready", 80'(in_ready_a), 80'd1);
        in_data_a = 8'h81; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        capture_a(40, v, lb);
        check("midrst_frame_81",   v,           80'hFF000000F0);
        check("midrst_busy_after", 80'(busy_a), 80'd0);

        // ---------------- FIFO fill / stall, CLK_DIV=8 ----------------
        hs = 0;
        guard = 0;
        nb = 8'h00;
        in_valid_b = 1'b1;
        while (in_ready_b && guard < 40) begin
            in_data_b = nb;
            exp_q.push_back(nb);
            nb++;
            hs++;
            guard++;
            step();
        end
        check("fill_handshakes", 80'(hs),         80'd17);
        check("fill_level",      80'(level_b),    80'd16);
        check("fill_in_ready",   80'(in_ready_b), 80'd0);

        // Junk values while stalled must never reach the line.
        stall = 0;
        while (!in_ready_b && stall < 200) begin
            in_data_b = 8'hC0 | 8'(stall[5:0]);
            stall++;
            step();
        end
        check("stall_cycles",   80'(stall),      80'd65);
        check("stall_released", 80'(in_ready_b), 80'd1);
        in_data_b = nb;
        exp_q.push_back(nb);
        hs++;
        step();
        in_data_b = 8'hEE;
        check("refill_in_ready", 80'(in_ready_b), 80'd0);
        check("refill_level",    80'(level_b),    80'd16);
        step();
        in_data_b = 8'hD7;
        check("refill_one_only", 80'(in_ready_b), 80'd0);
        step();
        in_valid_b = 1'b0;

        guard = 0;
        while (busy_b && guard < 3000) begin
            guard++;
            step();
        end
        check("drain_timeout", 80'(guard < 3000), 80'd1);
        check("drain_rx_count", 80'(rx_q.size()), 80'd18);
        check("drain_frame_err", 80'(frame_err_b), 80'd0);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check($sformatf("order_byte_%0h", want), 80'(got), 80'(want));
        end

        // ---------------- default divisor, 0x00 ----------------
        in_data_c = 8'h00; in_valid_c = 1'b1;
        step();
        in_valid_c = 1'b0;
        guard = 0;
        while (tx_c !== 1'b0 && guard < 5) begin
            guard++;
            step();
        end
        check("div417_start_seen", 80'(tx_c), 80'd0);
        low = 0;
        while (tx_c === 1'b0 && low < 5000) begin
            low++;
            step();
        end
        check("div417_low_period", 80'(low),  80'd3753);
        check("div417_stop_high",  80'(tx_c), 80'd1);
        guard = 0;
        while (busy_c && guard < 1000) begin
            guard++;
            step();
        end
        check("div417_stop_len", 80'(guard), 80'd417);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
